// File: rtl/spi_main.sv
// rtl/spi_main.sv - SPI mode-0 initiator for 44-bit {op, addr, data} frames toward spi_sub
// Optional macro SPI_MAIN_CSGAP_EN adds a GAP state holding cs_n high for CS_GAP clk after each frame.
module spi_main #(
    parameter int CLK_DIV = 4,
    parameter int RD_TURN = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(44 + RD_TURN + 1);
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] N_WR   = BW'(44);
    localparam logic [BW-1:0] N_RD   = BW'(44 + RD_TURN);

    if (CLK_DIV < 1 || CS_GAP < 0) begin : g_bad_params
        $error("spi_main: CLK_DIV must be >= 1 and CS_GAP >= 0");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_END, S_GAP} state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] nbits;
    logic [43:0]   shreg;
    logic [31:0]   rdata;
    logic          is_read;
    logic          h_term;
    logic          accept;
    logic          op_legal;

`ifdef SPI_MAIN_CSGAP_EN
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 1);
    logic [GW-1:0] gcnt;
`endif

    assign h_term   = (hcnt == H_LAST);
    assign accept   = req_valid && req_ready;
    assign op_legal = (req_op == 2'b01) || (req_op == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hcnt      <= '0;
            bcnt      <= '0;
            nbits     <= N_WR;
            shreg     <= '0;
            rdata     <= '0;
            is_read   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
`ifdef SPI_MAIN_CSGAP_EN
            gcnt      <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (op_legal) begin
                            // Reads send zeros after the header, so the data field is cleared.
                            state   <= S_SETUP;
                            busy    <= 1'b1;
                            cs_n    <= 1'b0;
                            mosi    <= req_op[1];
                            shreg   <= {req_op[0], req_addr,
                                        (req_op == 2'b00) ? 32'd0 : req_wdata, 1'b0};
                            is_read <= (req_op == 2'b00);
                            nbits   <= (req_op == 2'b00) ? N_RD : N_WR;
                            hcnt    <= '0;
                            bcnt    <= '0;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (h_term) begin
                        hcnt <= '0;
                        if (sclk) begin
                            sclk  <= 1'b0;
                            mosi  <= shreg[43];
                            shreg <= {shreg[42:0], 1'b0};
                        end else if (state == S_SHIFT && bcnt == nbits) begin
                            state <= S_END;
                        end else begin
                            // Only the last 32 sampled bits survive, which is the read data window.
                            state <= S_SHIFT;
                            sclk  <= 1'b1;
                            bcnt  <= bcnt + 1'b1;
                            rdata <= {rdata[30:0], miso};
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_END: begin
                    if (h_term) begin
                        hcnt      <= '0;
                        cs_n      <= 1'b1;
                        mosi      <= 1'b0;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_read ? rdata : 32'd0;
`ifdef SPI_MAIN_CSGAP_EN
                        state     <= S_GAP;
                        gcnt      <= '0;
`else
                        state     <= S_IDLE;
`endif
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
`ifdef SPI_MAIN_CSGAP_EN
                S_GAP: begin
                    if (gcnt == G_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
